// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity link: FSM state encoding,
// frame length and parity-mode constants.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int FRAME_LEN  = DEF_DATA_W + 3;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Frame period in clocks for an arbitrary data width.
    function automatic int frame_len(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/parity_accum.sv
// Running-parity toggle register, shared with the transmit-side generator.
// A load seeds the accumulator; each enabled 1 bit toggles it.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic din,
    output logic acc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (load) begin
            acc <= load_val;
        end else if (en && din) begin
            acc <= ~acc;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start 0, DATA_W bits LSB first, parity, stop 1.
// Presents each completed word with a one-cycle valid and error flags.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit ODD_PARITY = EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_shifted;
    logic              perr;
    logic              acc;
    logic              start, data_bit, parity_bit, complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        data_bit   = 1'b0;
        parity_bit = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (!x) begin
                    start      = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                data_bit = 1'b1;
                if (cnt == LAST_BIT) state_next = PARITY;
            end
            PARITY: begin
                parity_bit = 1'b1;
                state_next = STOP;
            end
            STOP: begin
                complete   = 1'b1;
                state_next = x ? IDLE : BREAK;
            end
            BREAK: begin
                if (x) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    parity_accum u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (ODD_PARITY),
        .en       (data_bit),
        .din      (x),
        .acc      (acc)
    );

    // Bits enter at the MSB and move right, so the first one ends at bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_1
            assign sreg_shifted = x;
        end else begin : g_shift_n
            assign sreg_shifted = {x, sreg[DATA_W-1:1]};
        end
    endgenerate

    // NOTE: the shift register is an ordinary register file here, so it is
    // reset along with everything else to give a defined post-reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sreg <= '0;
            perr <= 1'b0;
        end else begin
            if (start) begin
                cnt  <= '0;
                perr <= 1'b0;
            end
            if (data_bit) begin
                cnt  <= cnt + CNT_W'(1);
                sreg <= sreg_shifted;
            end
            if (parity_bit && (x != acc)) begin
                perr <= 1'b1;
            end
        end
    end

    // Flags are gated by completion so they never assert without valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid      <= complete;
            parity_err <= complete & perr;
            frame_err  <= complete & ~x;
            if (complete) data <= sreg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker: directed frames push expected
// words into queues, per-instance monitors pop and compare on each valid.
module tb_serial_parity_checker;
    import parity_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       x_e = 1'b1;
    logic       x_o = 1'b1;
    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   use_odd = 1'b0;
    exp_t q_e[$];
    exp_t q_o[$];

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(EVEN)) u_even (
        .clk(clk), .rst_n(rst_n), .x(x_e), .data(data_e), .valid(valid_e),
        .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e)
    );

    serial_parity_checker #(.DATA_W(8), .ODD_PARITY(ODD)) u_odd (
        .clk(clk), .rst_n(rst_n), .x(x_o), .data(data_o), .valid(valid_o),
        .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        if (use_odd) x_o = b;
        else         x_e = b;
        @(posedge clk);
        #1;
    endtask

    // Start, 8 data bits LSB first, parity, stop; expectation pushed after
    // the stop edge, tagged with the cycle in which valid must appear.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input logic eperr, input logic eferr);
        exp_t e;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(stop);
        e.data = d;
        e.perr = eperr;
        e.ferr = eferr;
        e.cyc  = cyc;
        if (use_odd) q_o.push_back(e);
        else         q_e.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    always @(negedge clk) begin
        if (valid_e) begin
            if (q_e.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL even_spurious_valid: data 0x%0h with no frame expected", data_e);
            end else begin
                exp_t e;
                e = q_e.pop_front();
                check("even_data", data_e, e.data);
                check("even_parity_err", perr_e, e.perr);
                check("even_frame_err", ferr_e, e.ferr);
                check("even_valid_cycle", cyc, e.cyc);
            end
        end else if (perr_e || ferr_e) begin
            checks++;
            errors++;
            $display("FAIL even_flags_without_valid: perr %0b ferr %0b", perr_e, ferr_e);
        end
    end

    always @(negedge clk) begin
        if (valid_o) begin
            if (q_o.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL odd_spurious_valid: data 0x%0h with no frame expected", data_o);
            end else begin
                exp_t e;
                e = q_o.pop_front();
                check("odd_data", data_o, e.data);
                check("odd_parity_err", perr_o, e.perr);
                check("odd_frame_err", ferr_o, e.ferr);
                check("odd_valid_cycle", cyc, e.cyc);
            end
        end else if (perr_o || ferr_o) begin
            checks++;
            errors++;
            $display("FAIL odd_flags_without_valid: perr %0b ferr %0b", perr_o, ferr_o);
        end
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data_e, 8'h00);
        check("reset_valid", valid_e, 1'b0);
        check("reset_flags", {perr_e, ferr_e}, 2'b00);
        check("reset_busy", busy_e, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // 0xA5, even parity 0, good stop
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("busy_after_good_stop", busy_e, 1'b0);
        idle(2);

        // Same word with wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // 0x07, correct parity 1, stop low then line held low
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        check("busy_after_low_stop", busy_e, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0);
            check("busy_in_break", busy_e, 1'b1);
        end
        send_bit(1'b1);
        check("busy_after_break", busy_e, 1'b0);
        idle(2);

        // Back-to-back frames: valid cycles must be FRAME_LEN apart
        t0 = cyc;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b_frame_span", cyc - t0, 2 * FRAME_LEN);
        idle(3);

        // Reset mid-frame after 4 data bits of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_data", data_e, 8'h00);
        check("midreset_valid", valid_e, 1'b0);
        check("midreset_busy", busy_e, 1'b0);
        x_e = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("post_reset_busy", busy_e, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Odd-parity instance
        use_odd = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        check("even_queue_drained", q_e.size(), 0);
        check("odd_queue_drained", q_o.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive-side counterpart of the serial running-parity generator. It deserialises a framed bitstream sampled one bit per clock: start bit 0, DATA_W data bits LSB first, one parity bit, stop bit 1. It checks the parity and stop bits and presents the word with a one-cycle valid pulse and error flags. It sits at the far end of the serial link, feeding downstream word-wide logic.

## Interface
- DATA_W, 8, number of data bits per frame (≥1)
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- x  input  1  serial line; idles at 1; one bit per clk
- data  output  DATA_W  last received word; held until the next valid
- valid  output  1  one-cycle pulse: new frame completed
- parity_err  output  1  qualified by valid; received parity mismatched
- frame_err  output  1  qualified by valid; stop bit sampled as 0
- busy  output  1  high whenever state ≠ IDLE

## Operation
- State machine:
  - IDLE: x=0 → DATA, clear bit counter, load parity accumulator with ODD_PARITY; x=1 → stay.
  - DATA: shift x into data shift register at MSB, shifting right, so the first bit lands at bit 0 after DATA_W shifts. Toggle accumulator when x=1. Increment counter. After DATA_W bits → PARITY.
  - PARITY: compare x against accumulator. Mismatch latches internal perr. → STOP.
  - STOP: x=1 → IDLE; x=0 → BREAK. Either way complete the frame.
  - BREAK: wait for x=1 → IDLE. Prevents a low stop/break being taken as a new start bit.
- Frame completion on the STOP-sampling edge registers the outputs:
  - data ← shift register
  - valid ← 1
  - parity_err ← perr
  - frame_err ← ~x
- valid pulses even on errors. parity_err and frame_err are 0 whenever valid is 0.
- Expected parity bit = XOR of data bits XOR ODD_PARITY.
- Counter width: clog2(DATA_W+1).
- Reset values:
  - state IDLE
  - data 0, valid 0, parity_err 0, frame_err 0, busy 0
  - counter, shift register, accumulator all 0

## Timing
- Edge E0 samples start bit. E1..E_DATA_W sample data. E_DATA_W+1 samples parity. E_DATA_W+2 samples stop.
- valid is high in the cycle after E_DATA_W+2 (for DATA_W=8: after E10, low again at E11).
- Back-to-back frames are supported: a start bit may be sampled at E_DATA_W+3, coincident with valid high. The frame period is DATA_W+3 cycles.
- A start pulse of any length during DATA, PARITY or STOP is treated as data, not a restart.
- Reset asserted mid-frame: all outputs go to reset values immediately. No valid for the partial frame. After release, the block waits in IDLE for the next 0.
- In BREAK, x=1 returns to IDLE on that edge. The earliest new start bit is the following edge.

## Structure
- Shared package parity_pkg:
  - state encoding (IDLE, DATA, PARITY, STOP, BREAK)
  - localparam FRAME_LEN = DATA_W+3
  - parity-mode constants EVEN=0, ODD=1
- One sub-module, parity_accum: running-parity toggle register. Inputs are clear/load value, enable, bit. The same function as the transmit-side generator, reused here.
- Top level holds the FSM, counter, shift register and output registers.

## Test plan
- Even parity, DATA_W=8, send 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 → one valid pulse after E10; data=0xA5; parity_err=0; frame_err=0; busy low after E10.
- Same frame with parity bit 1 → valid=1, data=0xA5, parity_err=1, frame_err=0.
- 0x07 (bits 1,1,1,0,0,0,0,0), parity 1, stop 0, then x=0 for 3 cycles, then 1:
  - valid=1, frame_err=1, parity_err=0
  - busy stays high until x returns to 1
  - no spurious frame during the low cycles
- Two back-to-back frames 0x3C then 0xC3, each with even parity 0 → valid pulses exactly 11 cycles apart, data 0x3C then 0xC3, no errors.
- Reset mid-frame: assert rst_n=0 after the 4th data bit of 0xFF. Outputs immediately reset, with no valid. After release, a full frame 0x55 is received correctly.
- ODD_PARITY=1, data 0x00, parity bit 1 → valid=1, data=0x00, parity_err=0. The same frame with parity bit 0 → parity_err=1.
